// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single regfile write port between the in-order writeback
//   stage (wb, always wins) and a multi-cycle unit (mc, valid/ready).
//   Tracks registers with an outstanding mc write so ID can detect RAW
//   hazards, and requests a pipeline bubble when mc is starved.
//   Optional feature macro: RF_ARB_BYPASS_EN adds same-cycle forwarding
//   of the regfile write data onto the two ID source operands.

`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module rf_write_arbiter #(
    parameter int RW           = `REG_ADDR_W,
    parameter int W            = `WORD_WIDTH,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic [RW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    input  logic          mc_issue_en,
    input  logic [RW-1:0] mc_issue_addr,
    input  logic          mc_valid,
    output logic          mc_ready,
    input  logic [RW-1:0] mc_addr,
    input  logic [W-1:0]  mc_data,
    input  logic [RW-1:0] rs_addr,
    input  logic [RW-1:0] rt_addr,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          stall_req,
    output logic          issue_conflict,
    output logic          write_en,
    output logic [RW-1:0] write_addr,
    output logic [W-1:0]  write_data
`ifdef RF_ARB_BYPASS_EN
    ,
    output logic          rs_fwd_valid,
    output logic          rt_fwd_valid,
    output logic [W-1:0]  rs_fwd_data,
    output logic [W-1:0]  rt_fwd_data
`endif
);

    localparam int NREGS = 2 ** RW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             conflict_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stall_req_q;
    logic             stall_req_d;

    // ------------------------------------------------------------------
    // Grant signals
    // ------------------------------------------------------------------
    logic wb_act;
    logic hs;
    logic blk;
    logic issue_set;
    logic issue_hits_busy;

    // Writeback has absolute priority; a write to $zero does not claim the port.
    always_comb begin
        // NOTE: every signal driven in a combinational block gets a default
        // first so no path leaves it unassigned and no latch is inferred.
        wb_act     = 1'b0;
        mc_ready   = 1'b0;
        hs         = 1'b0;
        blk        = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        if (rst) begin
            wb_act   = wb_en && (wb_addr != '0);
            mc_ready = !wb_act;
            hs       = mc_valid && mc_ready;
            blk      = mc_valid && !mc_ready;
            if (wb_act) begin
                write_en   = 1'b1;
                write_addr = wb_addr;
                write_data = wb_data;
            end else if (mc_valid && (mc_addr != '0)) begin
                // mc results aimed at $zero are accepted but never written.
                write_en   = 1'b1;
                write_addr = mc_addr;
                write_data = mc_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard of registers awaiting an mc result
    // ------------------------------------------------------------------
    assign issue_set       = mc_issue_en && (mc_issue_addr != '0);
    assign issue_hits_busy = mc_issue_en && busy_q[mc_issue_addr]
                             && !(hs && (mc_addr == mc_issue_addr));

    // Next scoreboard: retire the accepted result, then mark the new issue
    // so an issue to the register retiring this cycle stays busy.
    always_comb begin
        busy_d = busy_q;
        if (hs) begin
            busy_d[mc_addr] = 1'b0;
        end
        if (issue_set) begin
            busy_d[mc_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard and sticky conflict flag registers.
    always_ff @(posedge clk) begin
        // NOTE: the busy vector is control state, not storage, so every bit
        // is reset; a stale busy bit would stall ID forever.
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops sample pre-edge values regardless of statement order.
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_q || issue_hits_busy;
        end
    end

    assign issue_conflict = conflict_q;

    // ------------------------------------------------------------------
    // Starvation FSM
    // ------------------------------------------------------------------

    // State, counter and registered stall request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_req_q <= stall_req_d;
        end
    end

    // Next state: count consecutive blocked cycles; any unblocked cycle
    // (handshake or mc idle) returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (blk) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!blk) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) begin
                    state_d = ST_FORCE;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FORCE: begin
                if (!blk) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: the bubble request is registered from the next state
    // so it is high in every FORCE cycle, starting with the first.
    always_comb begin
        stall_req_d = (state_d == ST_FORCE);
    end

    assign stall_req = stall_req_q;

    // ------------------------------------------------------------------
    // Hazard outputs and optional forwarding
    // ------------------------------------------------------------------
`ifdef RF_ARB_BYPASS_EN
    // Forward the value being written this cycle and hide its busy flag.
    always_comb begin
        rs_fwd_valid = write_en && (write_addr == rs_addr) && (rs_addr != '0);
        rt_fwd_valid = write_en && (write_addr == rt_addr) && (rt_addr != '0);
        rs_fwd_data  = write_data;
        rt_fwd_data  = write_data;
        rs_busy      = rst && busy_q[rs_addr] && !rs_fwd_valid;
        rt_busy      = rst && busy_q[rt_addr] && !rt_fwd_valid;
    end
`else
    // Busy flags come straight from the registered scoreboard.
    always_comb begin
        rs_busy = rst && busy_q[rs_addr];
        rt_busy = rst && busy_q[rt_addr];
    end
`endif

endmodule
